// File: rtl/btn_input_conditioner.sv
// btn_input_conditioner
// Synchronises and debounces the eight board push-buttons ({BTN_7, BTN}),
// emits clean levels, one-cycle press pulses and an encoded key event.
// Optional feature macro: AUTOREPEAT_EN. When defined, a held button also
// produces repeat pulses after REPEAT_DELAY cycles, then every REPEAT_PERIOD
// cycles.
// Key event handshake: key_valid is a one-cycle strobe with no ready; the
// consumer must take key_code/key_multi in the cycle key_valid is high.
// key_code holds its value between events; key_multi is only meaningful
// while key_valid is high.
module btn_input_conditioner #(
  parameter int DB_CNT        = 1_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BTN_7,
  input  logic [6:0] BTN,
  output logic [7:0] btn_level,
  output logic [7:0] btn_pulse,
  output logic       key_valid,
  output logic [2:0] key_code,
  output logic       key_multi
);

  localparam int DB_W = $clog2(DB_CNT);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);

  logic [7:0]      sync_q1;
  logic [7:0]      sync_q2;
  logic [DB_W-1:0] db_cnt [8];
  logic [7:0]      flip;
  logic [7:0]      rise;
  logic [7:0]      fall;
  logic [7:0]      rep_fire;
  logic [2:0]      low_idx;
  logic            multi_hit;

  // Two-stage synchroniser on the raw, asynchronous button pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {BTN_7, BTN};
      sync_q2 <= sync_q1;
    end
  end

  // A bit flips when it has disagreed with its level for DB_CNT cycles.
  always_comb begin
    flip = '0;
    for (int i = 0; i < 8; i++) begin
      flip[i] = (sync_q2[i] != btn_level[i]) && (db_cnt[i] == DB_LAST);
    end
    rise = flip & sync_q2;
    fall = flip & ~sync_q2;
  end

  // Per-bit debounce counters, debounced levels and registered pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_level <= '0;
      btn_pulse <= '0;
      for (int i = 0; i < 8; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      btn_pulse <= rise | rep_fire;
      for (int i = 0; i < 8; i++) begin
        if (sync_q2[i] != btn_level[i]) begin
          if (flip[i]) begin
            btn_level[i] <= sync_q2[i];
            db_cnt[i]    <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0] hold_cnt [8];
  logic [7:0]        rep_armed;

  // Repeat fires when the hold counter reaches the current interval; a bit
  // being released on this edge never repeats.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < 8; i++) begin
      rep_fire[i] = btn_level[i] && !fall[i] &&
                    (hold_cnt[i] == (rep_armed[i] ? PERIOD_LAST : DELAY_LAST));
    end
  end

  // Hold counters run while the level is high; rep_armed selects the
  // first-delay versus steady-period interval.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_armed <= '0;
      for (int i = 0; i < 8; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (!btn_level[i] || fall[i]) begin
          hold_cnt[i]  <= '0;
          rep_armed[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          hold_cnt[i]  <= '0;
          rep_armed[i] <= 1'b1;
        end else begin
          hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
        end
      end
    end
  end
`else
  // Single pulse per press; repeat parameters have no effect in this build.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
  assign rep_fire = '0;
`endif

  // Lowest set pulse index and "more than one pulse" detection.
  always_comb begin
    low_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (btn_pulse[i]) begin
        low_idx = 3'(i);
      end
    end
    multi_hit = (btn_pulse & (btn_pulse - 8'd1)) != 8'd0;
  end

  // Registered key encoder, one edge behind btn_pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      key_multi <= 1'b0;
    end else begin
      key_valid <= |btn_pulse;
      key_multi <= multi_hit;
      if (|btn_pulse) begin
        key_code <= low_idx;
      end
    end
  end

endmodule

// File: tb/tb_btn_input_conditioner.sv
// Testbench for btn_input_conditioner with DB_CNT=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Key events are predicted into exp_q at the moment a
// press/repeat pulse is expected and checked by a monitor when key_valid
// strobes. Expectations follow AUTOREPEAT_EN if it is defined.
module tb_btn_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic       BTN_7;
  logic [6:0] BTN;
  logic [7:0] btn_level;
  logic [7:0] btn_pulse;
  logic       key_valid;
  logic [2:0] key_code;
  logic       key_multi;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];  // {key_code, key_multi}

  btn_input_conditioner #(
    .DB_CNT(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .BTN_7(BTN_7),
    .BTN(BTN),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_multi(key_multi)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] lowest(input logic [7:0] bits);
    logic [2:0] r = 3'd0;
    for (int i = 7; i >= 0; i--) if (bits[i]) r = 3'(i);
    return r;
  endfunction

  // Press pulse at k==0 relative to the press; repeats at 10, 13, 16, ...
  function automatic bit rep_hit(input int k);
`ifdef AUTOREPEAT_EN
    return (k == 0) || (k >= 10 && ((k - 10) % 3) == 0);
`else
    return (k == 0);
`endif
  endfunction

  // Step n edges. The press pulse is at step p_off; the level is high for
  // relative steps [0, l_len). Checks level and pulse every edge and
  // predicts a key event for each expected pulse.
  task automatic watch(input int n, input int p_off, input int l_len,
                       input logic [7:0] bits, input string tag);
    int rel;
    logic [7:0] exp_pulse;
    logic [7:0] exp_level;
    for (int k = 1; k <= n; k++) begin
      tick();
      rel = k - p_off;
      exp_level = (rel >= 0 && rel < l_len) ? bits : 8'h00;
      exp_pulse = (rel >= 0 && rel < l_len && rep_hit(rel)) ? bits : 8'h00;
      if (exp_pulse != 8'h00) exp_q.push_back({lowest(bits), $countones(bits) > 1});
      check({tag, "_level"}, btn_level, exp_level);
      check({tag, "_pulse"}, btn_pulse, exp_pulse);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, btn_level, 8'h00);
    check({tag, "_pulse"}, btn_pulse, 8'h00);
    check({tag, "_kvalid"}, key_valid, 1'b0);
    check({tag, "_kcode"}, key_code, 3'd0);
    check({tag, "_kmulti"}, key_multi, 1'b0);
  endtask

  // Scoreboard monitor: every key_valid must match the oldest prediction.
  always @(negedge clk) begin
    if (key_valid) begin
      if (exp_q.size() == 0) begin
        check("key_unexpected", 32'd1, 32'd0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("key_code", key_code, e[3:1]);
        check("key_multi", key_multi, e[0]);
      end
    end
  end

  // Directed stimulus
  initial begin
    rst_n = 1'b0;
    BTN_7 = 1'b0;
    BTN   = 7'h7F;

    // 1: reset held with buttons pressed, then released.
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    watch(8, 6, 100, 8'h7F, "rst_rel");
    BTN = 7'h00;
    watch(12, -2, 8, 8'h7F, "rst_up");

    // 2: 3-cycle glitches on BTN[2] never reach the level.
    for (int g = 0; g < 4; g++) begin
      BTN[2] = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        check("glitch_hi", btn_level, 8'h00);
      end
      BTN[2] = 1'b0;
      tick();
      check("glitch_lo", btn_level, 8'h00);
    end
    BTN[2] = 1'b1;
    watch(9, 6, 100, 8'h04, "b2_press");
    BTN[2] = 1'b0;
    watch(12, -3, 9, 8'h04, "b2_rel");

    // 3: BTN_7 held 20 cycles.
    BTN_7 = 1'b1;
    watch(20, 6, 100, 8'h80, "b7_press");
    BTN_7 = 1'b0;
    watch(12, -14, 20, 8'h80, "b7_rel");

    // 4: BTN[5] and BTN[3] rise together.
    BTN = 7'h28;
    watch(8, 6, 100, 8'h28, "dual_press");
    BTN = 7'h00;
    watch(12, -2, 8, 8'h28, "dual_rel");

    // 5: BTN[0] held 30 cycles past its press pulse.
    BTN[0] = 1'b1;
    watch(36, 6, 100, 8'h01, "b0_hold");
    BTN[0] = 1'b0;
    watch(14, -30, 36, 8'h01, "b0_rel");

    // 6: reset while BTN[1] debounce counter is at 2.
    BTN[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("mid_pre_pulse", btn_pulse, 8'h00);
    end
    rst_n = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    watch(9, 6, 100, 8'h02, "mid_press");
    BTN[1] = 1'b0;
    watch(12, -3, 9, 8'h02, "mid_rel");

    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_input_conditioner.md
# btn_input_conditioner

Front-end conditioner for the board push-buttons that feed the selecting machine. It synchronises and debounces BTN_7 and BTN[6:0] and emits clean debounced levels and one-cycle press pulses. It also emits an encoded key event (code + valid). The selecting machine consumes these outputs in place of raw button pins; raw pins are active-high and idle at 0.

## Interface
- DB_CNT, 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range ≥ 2.
- REPEAT_DELAY, 25_000_000: hold cycles before the first auto-repeat pulse (AUTOREPEAT_EN only).
- REPEAT_PERIOD, 5_000_000: cycles between subsequent auto-repeat pulses (AUTOREPEAT_EN only).

- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset: one clock; synchronous, active-low.
- BTN_7  in  1  raw button 7 (bit 7 of the internal vector), asynchronous.
- BTN  in  7  raw buttons 6..0, asynchronous.
- btn_level  out  8  debounced level, bit i = button i.
- btn_pulse  out  8  one-cycle press pulse per button.
- key_valid  out  1  one-cycle key event strobe.
- key_code  out  3  index of the reported button; held between events.
- key_multi  out  1  1 with key_valid when more than one btn_pulse bit was set.

## Operation
- Raw vector {BTN_7, BTN} passes through a 2-FF synchroniser per bit; synchroniser registers reset to 0.
- Each bit has its own debounce counter, of width $clog2(DB_CNT).
  - If sync != btn_level, the counter increments.
  - If sync == btn_level, the counter clears.
  - When the counter equals DB_CNT-1 and sync still differs, btn_level flips at the next edge and the counter clears.
- btn_pulse[i] is registered. It is 1 for exactly one cycle, on the same edge that btn_level[i] goes 0→1.
- Releases (1→0) produce no pulse.
- Encoder operates one edge after btn_pulse:
  - key_valid = |btn_pulse.
  - key_code = index of the lowest set bit of btn_pulse.
  - key_multi = popcount(btn_pulse) > 1.
  - key_code keeps its last value when key_valid = 0.
- A glitch shorter than DB_CNT cycles never changes btn_level, whatever its polarity.
- Reset values: all outputs 0; counters 0; synchronisers 0.
- Reset mid-operation clears all state immediately. A button still held at rst_n release is treated as a new press: btn_pulse fires DB_CNT+2 cycles after release.

## Timing
- Input change stable from edge t: synchroniser output changes at edge t+2.
- btn_level and btn_pulse change at edge t+DB_CNT+2.
- key_valid asserts at edge t+DB_CNT+3.
- Independent bits debounce in parallel, with no cross-coupling.
- Simultaneous qualifying presses produce a single key_valid, with the lowest index in key_code and key_multi = 1.
- Auto-repeat pulses follow the same encoder path and latency.

## Configuration
- AUTOREPEAT_EN defined:
  - Each bit has a hold counter, of width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)), which runs while btn_level[i] = 1.
  - Extra btn_pulse[i] fire REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles, until release.
  - Release or reset clears the hold counter.
  - Repeat pulses for different buttons coinciding in one cycle set key_multi as usual.
- AUTOREPEAT_EN undefined:
  - Exactly one pulse per press.
  - REPEAT_* parameters are ignored and no hold counters are synthesised.

## Test plan
The bench uses DB_CNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.

1. Reset: hold rst_n=0 with BTN=7'h7F, then release. Outputs stay 0 for 5 edges. btn_level=8'h7F and btn_pulse=8'h7F at release+6. key_valid=1, key_code=0, key_multi=1 at release+7.
2. Debounce: BTN[2] sees 3-cycle high glitches separated by 1-cycle lows. btn_level stays 0. A subsequent steady high gives btn_pulse=8'h04 at t+6, then key_code=2, key_multi=0 at t+7.
3. Single press/release: BTN_7 is high for 20 cycles. One btn_pulse=8'h80, key_code=7. btn_level[7] falls 6 cycles after release, with no pulse on release.
4. Simultaneous presses: BTN[5] and BTN[3] rise on the same edge. One key_valid, with key_code=3 and key_multi=1.
5. Auto-repeat (macro defined): BTN[0] is held for 30 cycles after the press pulse at p. Pulses occur at p, p+10, p+13, p+16, …; none after release. With the macro undefined, only the pulse at p occurs.
6. Mid-operation reset: rst_n=0 for 1 cycle while BTN[1] is held and its counter is at 2. Everything clears. The pulse reappears 6 cycles after rst_n returns high.
